// File: rtl/imm_extend_unit.sv
// Immediate-extension stage between decode and execute: widens an IN_W-bit immediate
// in one of four modes and buffers {result, tag, mode} in a DEPTH-entry output FIFO.
module imm_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_mode,
    input  logic [IN_W-1:0]              in_imm,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic [1:0]                   out_mode,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int K     = OUT_W - IN_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'b00,
        MODE_SIGN   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic [1:0]       mode;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             active;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_data;
    logic             push;
    logic             pop;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sext     = {{K{in_imm[IN_W-1]}}, in_imm};
        ext_data = '0;
        unique case (mode_e'(in_mode))
            MODE_ZERO:   ext_data = {{K{1'b0}}, in_imm};
            MODE_SIGN:   ext_data = sext;
            MODE_UPPER:  ext_data = {in_imm, {K{1'b0}}};
            MODE_BRANCH: ext_data = {sext[OUT_W-3:0], 2'b00};
            default:     ext_data = '0;
        endcase
    end

    // active holds in_ready low through reset and the first edge after release.
    assign in_ready  = active && (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is cleared on reset so the head reads zero and no stale entry survives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{data: ext_data, tag: in_tag, mode: in_mode};
        end
    end

    assign out_data = mem[rd_ptr].data;
    assign out_tag  = mem[rd_ptr].tag;
    assign out_mode = mem[rd_ptr].mode;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: constant vector table, directed handshake
// sequences, and randomized traffic checked against an arithmetic queue model.
module tb_imm_extend_unit;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               clock;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_mode;
    logic [IN_W-1:0]    in_imm;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic [1:0]         out_mode;
    logic [CNT_W-1:0]   count;

    imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_imm(in_imm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_mode(out_mode), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic [1:0]       mode;
    } exp_t;

    typedef struct {
        logic [1:0]       mode;
        logic [IN_W-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic [OUT_W-1:0] exp;
    } vec_t;

    exp_t model[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference extension computed numerically: interpret, scale, reduce modulo 2**OUT_W.
    function automatic longint unsigned ref_ext(input int mode, input longint unsigned imm);
        longint unsigned span = 64'd1 << OUT_W;
        longint          sv   = (imm >= (64'd1 << (IN_W - 1))) ? longint'(imm) - longint'(64'd1 << IN_W)
                                                               : longint'(imm);
        case (mode)
            0:       return imm % span;
            1:       return $unsigned(sv) % span;
            2:       return (imm * (64'd1 << (OUT_W - IN_W))) % span;
            default: return $unsigned(sv * 4) % span;
        endcase
    endfunction

    // One clock with the currently driven inputs; the model follows the handshakes.
    task automatic tick();
        logic push;
        logic pop;
        exp_t e;
        push   = in_valid && in_ready;
        pop    = out_valid && out_ready;
        e.data = OUT_W'(ref_ext(int'(in_mode), longint'(in_imm)));
        e.tag  = in_tag;
        e.mode = in_mode;
        @(negedge clock);
        if (pop && model.size() > 0) void'(model.pop_front());
        if (push) model.push_back(e);
    endtask

    task automatic check_model(input string name);
        check({name, " count"}, count, model.size());
        check({name, " out_valid"}, out_valid, model.size() != 0);
        if (model.size() != 0) begin
            check({name, " out_data"}, out_data, model[0].data);
            check({name, " out_tag"}, out_tag, model[0].tag);
            check({name, " out_mode"}, out_mode, model[0].mode);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b01, 16'hFFFE, 5'd1,  32'hFFFFFFFE};
        vecs[1] = '{2'b10, 16'hFFFE, 5'd2,  32'hFFFE0000};
        vecs[2] = '{2'b11, 16'hFFFE, 5'd3,  32'hFFFFFFF8};
        vecs[3] = '{2'b00, 16'hFFFE, 5'd4,  32'h0000FFFE};
        vecs[4] = '{2'b01, 16'h7FFF, 5'd5,  32'h00007FFF};
        vecs[5] = '{2'b01, 16'h8000, 5'd6,  32'hFFFF8000};
        vecs[6] = '{2'b11, 16'h7FFF, 5'd7,  32'h0001FFFC};
        vecs[7] = '{2'b11, 16'h8000, 5'd8,  32'hFFFE0000};
        vecs[8] = '{2'b10, 16'h0001, 5'd9,  32'h00010000};
        vecs[9] = '{2'b00, 16'h0000, 5'd10, 32'h00000000};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = '0; in_imm = '0; in_tag = '0;

        // Reset defaults, release, first push with one-cycle latency.
        repeat (2) @(negedge clock);
        check("rst count", count, 0);
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 0);
        check("rst out_data", out_data, 0);
        check("rst out_tag", out_tag, 0);
        check("rst out_mode", out_mode, 0);
        reset = 1'b1;
        @(negedge clock);
        check("post-rst in_ready", in_ready, 1);
        check("post-rst count", count, 0);
        in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'b00; in_tag = 5'd0;
        @(negedge clock);
        in_valid = 1'b0;
        check("first out_valid", out_valid, 1);
        check("first out_data", out_data, 32'h00008001);
        check("first count", count, 1);
        out_ready = 1'b1;
        @(negedge clock);
        check("first drained count", count, 0);
        check("first drained out_valid", out_valid, 0);

        // Vector table streamed with out_ready high: each result appears one cycle after its push.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_mode = vecs[i].mode; in_imm = vecs[i].imm; in_tag = vecs[i].tag;
            @(negedge clock);
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp);
            check($sformatf("vec%0d out_tag", i), out_tag, vecs[i].tag);
            check($sformatf("vec%0d out_mode", i), out_mode, vecs[i].mode);
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("vec drained count", count, 0);

        // Backpressure: fill, refuse a third push, hold head, no pass-through when full.
        out_ready = 1'b0; in_valid = 1'b1;
        in_imm = 16'h1111; in_mode = 2'b01; in_tag = 5'd7;
        @(negedge clock);
        in_imm = 16'h2222; in_mode = 2'b10; in_tag = 5'd8;
        @(negedge clock);
        check("full count", count, 2);
        check("full in_ready", in_ready, 0);
        check("full out_data", out_data, 32'h00001111);
        check("full out_tag", out_tag, 7);
        in_imm = 16'h3333; in_mode = 2'b00; in_tag = 5'd9;
        @(negedge clock);
        check("held count", count, 2);
        check("held out_data", out_data, 32'h00001111);
        out_ready = 1'b1;
        @(negedge clock);
        check("pop-at-full count", count, 1);
        check("pop-at-full out_data", out_data, 32'h22220000);
        check("pop-at-full out_tag", out_tag, 8);
        check("pop-at-full in_ready", in_ready, 1);
        out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        check("late push count", count, 2);
        out_ready = 1'b1;
        @(negedge clock);
        check("drain1 out_data", out_data, 32'h00003333);
        check("drain1 out_tag", out_tag, 9);
        check("drain1 count", count, 1);
        @(negedge clock);
        check("drain2 count", count, 0);

        // Continuous streaming across the sign boundary with pointer wrap.
        model.delete();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_imm = 16'(16'h7FF6 + i); in_mode = 2'(i % 4); in_tag = 5'(i);
            tick();
            check_model($sformatf("stream%0d", i));
            check($sformatf("stream%0d occupancy", i), count, 1);
        end
        in_valid = 1'b0;
        tick();
        check_model("stream drain");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom);
            in_imm    = 16'($urandom);
            in_tag    = 5'($urandom);
            tick();
            check_model($sformatf("rand%0d", i));
        end

        // Asynchronous reset while full discards everything immediately.
        in_valid = 1'b1; out_ready = 1'b0;
        in_imm = 16'hAAAA; in_mode = 2'b01; in_tag = 5'd21;
        tick();
        in_imm = 16'h5555; in_mode = 2'b11; in_tag = 5'd22;
        tick();
        check("pre-reset count", count, 2);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst count", count, 0);
        check("async rst in_ready", in_ready, 0);
        check("async rst out_data", out_data, 0);
        check("async rst out_tag", out_tag, 0);
        model.delete();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("re-release in_ready", in_ready, 1);
        check("re-release out_valid", out_valid, 0);
        in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b01; in_tag = 5'd3;
        tick();
        check_model("after reset");
        check("after reset out_data", out_data, 32'h00001234);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Popping an empty FIFO never underflows.
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("empty%0d count", i), count, 0);
            check($sformatf("empty%0d out_valid", i), out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
